muldiv: RTL and testbench
=========================

# muldiv

Iterative multiply/divide unit in the EX stage of the pipelined LEGv8 core. It consumes the ID/EX pipeline register outputs (forwarded Rn/Rm operands and a decoded multiply/divide opcode) and executes MUL, SMULH, UMULH, SDIV and UDIV over multiple cycles. While it works, it holds `busy` high so the hazard logic stalls PC, IF/ID and ID/EX. It presents a 64-bit result to the EX/MEM mux for one `done` cycle.

## Interface
Parameters:
- `WIDTH`, default `WORDSIZE` (64): operand and result width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  the ID/EX instruction is a mul/div and its control is not squashed.
- `mdop`  in  `MDOPSIZE` (3)  operation select: 0 MUL, 1 SMULH, 2 UMULH, 3 SDIV, 4 UDIV; 5–7 reserved.
- `a`  in  `WIDTH`  Rn after forwarding.
- `b`  in  `WIDTH`  Rm after forwarding.
- `flush`  in  1  kills the operation in flight (branch mispredict or exception).
- `busy`  out  1  stall request; combinational.
- `done`  out  1  result valid this cycle; registered state decode.
- `result`  out  `WIDTH`  result register.

## Operation
- State machine with states IDLE, RUN and DONE, plus a 7-bit iteration counter.
- **IDLE**
  - `start` latches `mdop`, `a` and `b`.
  - Operands are stored as magnitudes for the signed ops (SMULH, SDIV). The result sign is recorded: sign(a) XOR sign(b).
  - Next state is RUN with counter = 0.
  - Exception: UDIV or SDIV with b = 0 goes straight to DONE with result = 0. This matches ARMv8 divide-by-zero semantics.
- **RUN, multiply**
  - Radix-2 shift-add into a 128-bit accumulator, one bit per cycle, 64 cycles.
- **RUN, divide**
  - Restoring division, one quotient bit per cycle, 64 cycles.
- **Leaving RUN** (counter = 63):
  - Apply sign fixup as the 128-bit negation (product) or 64-bit negation (quotient) when the recorded sign is 1.
  - Select the output: MUL takes the low 64 bits; SMULH and UMULH take the high 64 bits; SDIV and UDIV take the quotient.
  - Write `result` and go to DONE.
- **DONE**
  - `done` = 1; go to IDLE unconditionally.
  - `start` is ignored in DONE, because the same instruction is still in ID/EX during this cycle.
- **Arithmetic rules**
  - Division truncates toward zero.
  - SDIV of 0x8000_0000_0000_0000 by −1 yields 0x8000_0000_0000_0000 (wraps naturally through the magnitude path).
- **Reserved `mdop`**: treated as MUL.
- **`result` hold**: holds its value until the next result write or reset. Operand inputs are don't-care after the latch.

## Timing
- Reset values: state IDLE, counter 0, `result` 0, `done` 0, `busy` 0. `rst` forces `busy` low in the same cycle.
- `busy` = !rst && !flush && ((IDLE && start) || RUN).
- Normal latency, with `start` sampled in cycle 0:
  - RUN occupies cycles 1–64.
  - DONE is cycle 65: `done` = 1, `busy` = 0, so the pipeline advances and EX/MEM captures `result`.
  - `busy` is high in cycles 0–64.
- Divide-by-zero latency: `busy` is high in cycle 0 only; DONE in cycle 1.
- Back-to-back: a new `start` is accepted in the IDLE cycle immediately after DONE.
- `flush` has priority below `rst` and above everything else:
  - Next state is IDLE, with no `done` and `result` unchanged.
  - `flush` together with `start` in IDLE means no accept.
- `rst` mid-RUN returns to IDLE next cycle with all outputs at their reset values.

## Structure
- Add `MDOPSIZE` and the `MDOP_MUL`, `MDOP_SMULH`, `MDOP_UMULH`, `MDOP_SDIV` and `MDOP_UDIV` encodings to `bus.vh`. The decoder and the ID/EX register share them.
- Add the state encodings to `bus.vh` as `MD_IDLE`, `MD_RUN` and `MD_DONE`.
- Single module, with no sub-module; the datapaths share the counter and FSM.
- The hazard unit ORs `busy` into its stall term.

## Test plan
- MUL a=7, b=0xFFFF_FFFF_FFFF_FFFD → `result` 0xFFFF_FFFF_FFFF_FFEB with `done` in cycle 65; `busy` high in cycles 0–64 exactly.
- UMULH a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. SMULH with the same operands → 0x0000_0000_0000_0000.
- SDIV: −7/2 → 0xFFFF_FFFF_FFFF_FFFD; 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000. UDIV: 100/7 → 14.
- UDIV 5/0 → `done` in cycle 1 and `result` 0; `busy` high in cycle 0 only.
- `flush` in cycle 30 of a MUL → IDLE in cycle 31, no `done`, `result` keeps the previous value. A new UDIV 9/3 is accepted in cycle 31 → `result` 3.
- Two cases in one scenario, with a MUL in flight:
  - `rst` in cycle 40 → all outputs 0 from cycle 41.
  - Separately, `start` held through DONE then re-asserted in IDLE → exactly two `done` pulses, 66 cycles apart.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: opcode select
// values used by the decoder and ID/EX register, and the unit's FSM states.
package muldiv_pkg;

   localparam int WORDSIZE = 64;
   localparam int MDOPSIZE = 3;

   localparam logic [MDOPSIZE-1:0] MDOP_MUL   = 3'd0;
   localparam logic [MDOPSIZE-1:0] MDOP_SMULH = 3'd1;
   localparam logic [MDOPSIZE-1:0] MDOP_UMULH = 3'd2;
   localparam logic [MDOPSIZE-1:0] MDOP_SDIV  = 3'd3;
   localparam logic [MDOPSIZE-1:0] MDOP_UDIV  = 3'd4;

   localparam logic [1:0] MD_IDLE = 2'd0;
   localparam logic [1:0] MD_RUN  = 2'd1;
   localparam logic [1:0] MD_DONE = 2'd2;

   function automatic logic is_div(input logic [MDOPSIZE-1:0] op);
      return (op == MDOP_SDIV) || (op == MDOP_UDIV);
   endfunction

   function automatic logic is_signed_op(input logic [MDOPSIZE-1:0] op);
      return (op == MDOP_SMULH) || (op == MDOP_SDIV);
   endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative 64-cycle multiply/divide unit for the EX stage. Multiply and
// restoring divide share one double-width shift register and the FSM counter.
module muldiv
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WORDSIZE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [MDOPSIZE-1:0] mdop,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   input  logic                flush,
   output logic                busy,
   output logic                done,
   output logic [WIDTH-1:0]    result
);

   localparam logic [6:0] LAST = 7'(WIDTH - 1);

   logic [1:0]          state_reg, state_next;
   logic [6:0]          count_reg, count_next;
   logic [MDOPSIZE-1:0] op_reg;
   logic                neg_reg;
   logic [2*WIDTH-1:0]  p_reg;
   logic [WIDTH-1:0]    d_reg;
   logic [WIDTH-1:0]    result_reg;

   logic [MDOPSIZE-1:0] op_in;
   logic                signed_in, div_in, div_zero, neg_in;
   logic [WIDTH-1:0]    a_mag, b_mag;

   logic [WIDTH:0]      mul_sum;
   logic [WIDTH:0]      div_shift, div_diff;
   logic                div_ok;
   logic [2*WIDTH-1:0]  mul_step, div_step, step, prod_fix;
   logic [WIDTH-1:0]    quo_fix, final_res;

   logic accept, last;

   // Operand capture: reserved opcodes fold onto MUL, signed ops keep magnitudes.
   always_comb begin
      op_in     = (mdop > MDOP_UDIV) ? MDOP_MUL : mdop;
      signed_in = is_signed_op(op_in);
      div_in    = is_div(op_in);
      div_zero  = div_in && (b == '0);
      neg_in    = signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
      a_mag     = (signed_in && a[WIDTH-1]) ? -a : a;
      b_mag     = (signed_in && b[WIDTH-1]) ? -b : b;
   end

   assign accept = (state_reg == MD_IDLE) && start && !flush;
   assign last   = (count_reg == LAST);

   always_comb begin
      // Multiply: high half accumulates, low half holds the shifting multiplier.
      mul_sum  = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, d_reg} : '0);
      mul_step = {mul_sum, p_reg[WIDTH-1:1]};

      // Divide: high half is the partial remainder, low half dividend/quotient.
      // The shifted remainder is below 2*divisor, so bit WIDTH of the
      // difference is set exactly when the trial subtraction underflows.
      div_shift = {p_reg[2*WIDTH-1:WIDTH], p_reg[WIDTH-1]};
      div_diff  = div_shift - {1'b0, d_reg};
      div_ok    = !div_diff[WIDTH];
      div_step  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   p_reg[WIDTH-2:0], div_ok};

      step     = is_div(op_reg) ? div_step : mul_step;
      prod_fix = neg_reg ? -step : step;
      quo_fix  = neg_reg ? -step[WIDTH-1:0] : step[WIDTH-1:0];

      case (op_reg)
         MDOP_SMULH, MDOP_UMULH: final_res = prod_fix[2*WIDTH-1:WIDTH];
         MDOP_SDIV, MDOP_UDIV:   final_res = quo_fix;
         default:                final_res = prod_fix[WIDTH-1:0];
      endcase
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      if (flush) begin
         state_next = MD_IDLE;
         count_next = '0;
      end else begin
         case (state_reg)
            MD_IDLE: begin
               if (start) begin
                  state_next = div_zero ? MD_DONE : MD_RUN;
                  count_next = '0;
               end
            end
            MD_RUN: begin
               if (last) begin
                  state_next = MD_DONE;
                  count_next = '0;
               end else begin
                  count_next = count_reg + 7'd1;
               end
            end
            // start is ignored here: the same instruction still sits in ID/EX.
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= MD_IDLE;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_reg     <= MDOP_MUL;
         neg_reg    <= 1'b0;
         p_reg      <= '0;
         d_reg      <= '0;
         result_reg <= '0;
      end else if (!flush) begin
         if (accept) begin
            op_reg  <= op_in;
            neg_reg <= neg_in;
            p_reg   <= {{WIDTH{1'b0}}, (div_in ? a_mag : b_mag)};
            d_reg   <= div_in ? b_mag : a_mag;
            if (div_zero) begin
               result_reg <= '0;
            end
         end else if (state_reg == MD_RUN) begin
            p_reg <= step;
            if (last) begin
               result_reg <= final_res;
            end
         end
      end
   end

   assign busy   = !rst && !flush && (((state_reg == MD_IDLE) && start) || (state_reg == MD_RUN));
   assign done   = (state_reg == MD_DONE);
   assign result = result_reg;

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: each task drives one scenario and checks its
// own observations against hand-computed values.
module tb_muldiv;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  mdop;
   logic [63:0] a;
   logic [63:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [63:0] result;

   int errors = 0;
   int checks = 0;

   muldiv #(.WIDTH(64)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .mdop(mdop),
      .a(a),
      .b(b),
      .flush(flush),
      .busy(busy),
      .done(done),
      .result(result)
   );

   always #5 clk = ~clk;

   // Entered and left at posedge+1; samples at the following negedge.
   // Cycle 0 is the cycle in which start is presented.
   task automatic do_op(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y,
                        output logic [63:0] res, output int done_cyc,
                        output int busy_cnt, output int busy_last);
      res = 'x;
      done_cyc = -1;
      busy_cnt = 0;
      busy_last = -1;
      mdop = op;
      a = x;
      b = y;
      start = 1'b1;
      for (int c = 0; c < 200 && done_cyc < 0; c++) begin
         #4;
         if (busy) begin
            busy_cnt++;
            busy_last = c;
         end
         if (done) begin
            done_cyc = c;
            res = result;
         end
         @(posedge clk);
         #1;
         if (c == 0) begin
            start = 1'b0;
            a = 64'h0;
            b = 64'h0;
         end
      end
      $display("txn op=%0d a=%h b=%h result=%h done_cycle=%0d busy_cycles=%0d",
               op, x, y, res, done_cyc, busy_cnt);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      mdop = MDOP_MUL;
      a = 64'd3;
      b = 64'd4;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy_forced: busy=%b expected 0", busy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      start = 1'b0;
      #1;
      checks++;
      if (done !== 1'b0 || result !== 64'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: done=%b busy=%b result=%h expected 0/0/0", done, busy, result);
      end
      @(posedge clk);
      #1;
      $display("txn reset done=%b busy=%b result=%h", done, busy, result);
   endtask

   task automatic test_mul;
      logic [63:0] r;
      int dc, bc, bl;
      do_op(MDOP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, r, dc, bc, bl);
      checks++;
      if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         errors++;
         $display("FAIL mul_neg_result: got %h expected ffffffffffffffeb", r);
      end
      checks++;
      if (dc !== 65) begin
         errors++;
         $display("FAIL mul_done_cycle: got %0d expected 65", dc);
      end
      checks++;
      if (bc !== 65 || bl !== 64) begin
         errors++;
         $display("FAIL mul_busy_window: count=%0d last=%0d expected 65/64", bc, bl);
      end
      do_op(MDOP_MUL, 64'h1_0000_0001, 64'h1_0000_0001, r, dc, bc, bl);
      checks++;
      if (r !== 64'h0000_0002_0000_0001) begin
         errors++;
         $display("FAIL mul_wide_low: got %h expected 0000000200000001", r);
      end
      do_op(3'd7, 64'd6, 64'd7, r, dc, bc, bl);
      checks++;
      if (r !== 64'd42) begin
         errors++;
         $display("FAIL reserved_as_mul: got %h expected 2a", r);
      end
   endtask

   task automatic test_mulh;
      logic [63:0] r;
      int dc, bc, bl;
      do_op(MDOP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, dc, bc, bl);
      checks++;
      if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         errors++;
         $display("FAIL umulh_ones: got %h expected fffffffffffffffe", r);
      end
      do_op(MDOP_SMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, dc, bc, bl);
      checks++;
      if (r !== 64'h0) begin
         errors++;
         $display("FAIL smulh_ones: got %h expected 0", r);
      end
      do_op(MDOP_SMULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, r, dc, bc, bl);
      checks++;
      if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++;
         $display("FAIL smulh_neg: got %h expected ffffffffffffffff", r);
      end
      do_op(MDOP_UMULH, 64'h1_0000_0001, 64'h1_0000_0001, r, dc, bc, bl);
      checks++;
      if (r !== 64'h1) begin
         errors++;
         $display("FAIL umulh_small: got %h expected 1", r);
      end
   endtask

   task automatic test_div;
      logic [63:0] r;
      int dc, bc, bl;
      do_op(MDOP_SDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, dc, bc, bl);
      checks++;
      if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         errors++;
         $display("FAIL sdiv_neg7_by_2: got %h expected fffffffffffffffd", r);
      end
      do_op(MDOP_SDIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, r, dc, bc, bl);
      checks++;
      if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         errors++;
         $display("FAIL sdiv_7_by_neg2: got %h expected fffffffffffffffd", r);
      end
      do_op(MDOP_SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, dc, bc, bl);
      checks++;
      if (r !== 64'h8000_0000_0000_0000) begin
         errors++;
         $display("FAIL sdiv_min_by_neg1: got %h expected 8000000000000000", r);
      end
      do_op(MDOP_UDIV, 64'd100, 64'd7, r, dc, bc, bl);
      checks++;
      if (r !== 64'd14 || dc !== 65) begin
         errors++;
         $display("FAIL udiv_100_by_7: got %h at cycle %0d expected e at cycle 65", r, dc);
      end
   endtask

   task automatic test_flush;
      logic [63:0] r;
      int dc, bc, bl;
      int seen_done;
      seen_done = 0;
      mdop = MDOP_MUL;
      a = 64'd5;
      b = 64'd5;
      start = 1'b1;
      for (int c = 0; c <= 30; c++) begin
         #4;
         if (done) seen_done++;
         if (c == 30) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL flush_busy_low: busy=%b expected 0", busy);
            end
         end
         @(posedge clk);
         #1;
         if (c == 0) start = 1'b0;
         if (c == 29) flush = 1'b1;
         if (c == 30) flush = 1'b0;
      end
      checks++;
      if (seen_done !== 0 || done !== 1'b0 || busy !== 1'b0 || result !== 64'd14) begin
         errors++;
         $display("FAIL flush_idle: dones=%0d done=%b busy=%b result=%h expected 0/0/0/e",
                  seen_done, done, busy, result);
      end
      $display("txn flush cycle=30 result=%h", result);
      do_op(MDOP_UDIV, 64'd9, 64'd3, r, dc, bc, bl);
      checks++;
      if (r !== 64'd3 || dc !== 65) begin
         errors++;
         $display("FAIL flush_then_udiv: got %h at cycle %0d expected 3 at cycle 65", r, dc);
      end
   endtask

   task automatic test_div_zero;
      logic [63:0] r;
      int dc, bc, bl;
      do_op(MDOP_UDIV, 64'd5, 64'd0, r, dc, bc, bl);
      checks++;
      if (r !== 64'h0 || dc !== 1) begin
         errors++;
         $display("FAIL udiv_by_zero: got %h at cycle %0d expected 0 at cycle 1", r, dc);
      end
      checks++;
      if (bc !== 1 || bl !== 0) begin
         errors++;
         $display("FAIL udiv_by_zero_busy: count=%0d last=%0d expected 1/0", bc, bl);
      end
   endtask

   task automatic test_back_to_back;
      int pulses, first, second;
      logic [63:0] r2;
      pulses = 0;
      first = -1;
      second = -1;
      r2 = 'x;
      mdop = MDOP_MUL;
      a = 64'd3;
      b = 64'd5;
      start = 1'b1;
      for (int c = 0; c <= 140; c++) begin
         #4;
         if (done) begin
            pulses++;
            if (first < 0) first = c;
            else if (second < 0) begin
               second = c;
               r2 = result;
            end
         end
         if (c == 65) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL b2b_busy_in_done: busy=%b expected 0", busy);
            end
         end
         @(posedge clk);
         #1;
         if (c == 131) start = 1'b0;
      end
      $display("txn back_to_back pulses=%0d first=%0d second=%0d result=%h", pulses, first, second, r2);
      checks++;
      if (pulses !== 2 || first !== 65 || second !== 131) begin
         errors++;
         $display("FAIL b2b_pulses: count=%0d first=%0d second=%0d expected 2/65/131",
                  pulses, first, second);
      end
      checks++;
      if (r2 !== 64'd15) begin
         errors++;
         $display("FAIL b2b_result: got %h expected f", r2);
      end
   endtask

   task automatic test_reset_mid;
      mdop = MDOP_MUL;
      a = 64'd5;
      b = 64'd6;
      start = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) start = 1'b0;
      end
      rst = 1'b1;
      #4;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_busy: busy=%b expected 0", busy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #4;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 64'h0) begin
         errors++;
         $display("FAIL rst_mid_outputs: busy=%b done=%b result=%h expected 0/0/0", busy, done, result);
      end
      repeat (70) @(posedge clk);
      #4;
      checks++;
      if (done !== 1'b0 || result !== 64'h0) begin
         errors++;
         $display("FAIL rst_mid_no_resume: done=%b result=%h expected 0/0", done, result);
      end
      $display("txn reset_mid busy=%b done=%b result=%h", busy, done, result);
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_flush();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
